// File: rtl/uart_tx.sv
// uart_tx: 8N1 asynchronous serial transmitter with a start/busy host handshake.
// Bit timing is an integer divider of the system clock (CLK_FREQ / BAUD_RATE).
// Optional feature: define UART_TX_PARITY_EN to insert a parity cell between the
// last data bit and the stop bit (even parity, or odd when PARITY_ODD = 1).
module uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    // Elaboration-time parameter sanity checks.
    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_parity_check
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_reg;
    logic [CNT_W-1:0] clk_cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             tx_reg;
    logic             busy_reg;
`ifdef UART_TX_PARITY_EN
    logic             parity_reg;
`endif

    // High on the last clock of every bit cell; the bit advances on that edge.
    logic cnt_last;
    assign cnt_last = (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

    // Frame sequencer: every output is registered so tx changes only on clk edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                    if (tx_start) begin
                        // Start bit goes out on the accepting edge itself.
                        shift_reg   <= tx_data;
                        clk_cnt_reg <= '0;
                        tx_reg      <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= START;
`ifdef UART_TX_PARITY_EN
                        parity_reg  <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                START: begin
                    if (cnt_last) begin
                        clk_cnt_reg <= '0;
                        bit_idx_reg <= '0;
                        tx_reg      <= shift_reg[0];
                        state_reg   <= DATA;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        clk_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_reg    <= parity_reg;
                            state_reg <= PARITY;
`else
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
`endif
                        end else begin
                            // LSB first: the next bit is always at position 1 before the shift.
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt_last) begin
                        clk_cnt_reg <= '0;
                        tx_reg      <= 1'b1;
                        state_reg   <= STOP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt_last) begin
                        // Busy drops on the final stop clock so the next request
                        // can be accepted on the very next edge.
                        clk_cnt_reg <= '0;
                        busy_reg    <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_reg;
    assign tx_busy = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. A line monitor decodes frames from tx
// (mid-cell samples plus a per-cell stability check) and measures tx_busy length;
// expected bytes are queued when driven and compared when a frame is decoded.
// A reduced divider (1 MHz / 57600 -> 17 clocks per bit) keeps the run short.
module tb_uart_tx;

    localparam int CPB = 17;              // 1_000_000 / 57_600, truncated
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int TIMEOUT = 2 * FRAME_BITS * CPB + 20;

    typedef struct {
        logic [10:0] cells;
        bit          stable;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;

    int checks = 0;
    int errors = 0;

    frame_t     rx_q[$];
    int         len_q[$];
    logic [7:0] exp_q[$];

    uart_tx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (57_600),
        .PARITY_ODD(0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    // Expected line cells, index 0 = start bit.
    function automatic logic [10:0] build_cells(input logic [7:0] d);
        logic [10:0] c;
        c      = '0;
        c[8:1] = d;
`ifdef UART_TX_PARITY_EN
        c[9]   = ^d;
        c[10]  = 1'b1;
`else
        c[9]   = 1'b1;
`endif
        return c;
    endfunction

    // Line monitor, sampling on the falling edge.
    initial begin : monitor
        bit     in_frame;
        int     n;
        int     bcnt;
        logic   prev;
        logic   first;
        frame_t f;
        in_frame = 0;
        n        = 0;
        bcnt     = 0;
        prev     = 1'b1;
        first    = 1'b1;
        f.cells  = '0;
        f.stable = 1'b1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                in_frame = 0;
                prev     = 1'b1;
                bcnt     = 0;
            end else begin
                if (tx_busy === 1'b1) begin
                    bcnt++;
                end else if (bcnt != 0) begin
                    len_q.push_back(bcnt);
                    bcnt = 0;
                end
                if (!in_frame && prev === 1'b1 && tx === 1'b0) begin
                    in_frame = 1;
                    n        = 0;
                    f.cells  = '0;
                    f.stable = 1'b1;
                end
                if (in_frame) begin
                    if (n % CPB == 0) first = tx;
                    else if (tx !== first) f.stable = 1'b0;
                    if (n % CPB == CPB / 2) f.cells[n / CPB] = tx;
                    if (n == FRAME_BITS * CPB - 1) begin
                        rx_q.push_back(f);
                        in_frame = 0;
                    end
                    n++;
                end
                prev = tx;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d);
        @(posedge clk); #1;
        tx_start = 1'b1;
        tx_data  = d;
        exp_q.push_back(d);
        @(posedge clk); #1;
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic get_frame(output frame_t f, output bit ok);
        int k;
        k = 0;
        while (rx_q.size() == 0 && k < TIMEOUT) begin
            @(posedge clk);
            k++;
        end
        ok = (rx_q.size() != 0);
        f.cells  = '0;
        f.stable = 1'b0;
        if (ok) f = rx_q.pop_front();
    endtask

    task automatic get_len(output int len, output bit ok);
        int k;
        k = 0;
        while (len_q.size() == 0 && k < TIMEOUT) begin
            @(posedge clk);
            k++;
        end
        ok  = (len_q.size() != 0);
        len = ok ? len_q.pop_front() : -1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #5 tx_start = ~tx_start;
            checks++;
            if (tx !== 1'b1 || tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold got tx=%b busy=%b required tx=1 busy=0", tx, tx_busy);
            end
        end
        tx_start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL reset_release got tx=%b busy=%b frames=%0d required tx=1 busy=0 frames=0",
                     tx, tx_busy, rx_q.size());
        end
        $display("reset: tx=%b busy=%b", tx, tx_busy);
    endtask

    task automatic test_frames();
        logic [7:0] bytes [3];
        frame_t     f;
        bit         ok;
        bit         lok;
        int         len;
        logic [7:0] e;
        bytes = '{8'hAA, 8'h00, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i]);
            checks++;
            if (tx !== 1'b0 || tx_busy !== 1'b1) begin
                errors++;
                $display("FAIL accept_latency got tx=%b busy=%b required tx=0 busy=1", tx, tx_busy);
            end
            get_frame(f, ok);
            get_len(len, lok);
            e = exp_q.pop_front();
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL frame_timeout got none required byte %h", e);
            end else begin
                checks++;
                if (f.cells !== build_cells(e)) begin
                    errors++;
                    $display("FAIL frame_cells got %b required %b", f.cells, build_cells(e));
                end
                checks++;
                if (!f.stable) begin
                    errors++;
                    $display("FAIL cell_width byte %h got unstable cell required %0d-clock cells", e, CPB);
                end
            end
            checks++;
            if (!lok || len != FRAME_BITS * CPB) begin
                errors++;
                $display("FAIL busy_len got %0d required %0d", len, FRAME_BITS * CPB);
            end
            $display("frame: byte %h cells %b busy %0d", e, f.cells, len);
        end
    endtask

    task automatic test_ignored_start();
        frame_t     f;
        bit         ok;
        bit         lok;
        int         len;
        logic [7:0] e;
        send_byte(8'hAA);
        repeat (5 * CPB) @(posedge clk);
        #1;
        tx_start = 1'b1;
        tx_data  = 8'h55;
        @(posedge clk); #1;
        tx_start = 1'b0;
        get_frame(f, ok);
        get_len(len, lok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || f.cells !== build_cells(e) || !f.stable) begin
            errors++;
            $display("FAIL ignored_frame got %b required %b", f.cells, build_cells(e));
        end
        checks++;
        if (!lok || len != FRAME_BITS * CPB) begin
            errors++;
            $display("FAIL ignored_busy_len got %0d required %0d", len, FRAME_BITS * CPB);
        end
        repeat (3 * FRAME_BITS * CPB) @(posedge clk);
        #1;
        checks++;
        if (rx_q.size() != 0 || len_q.size() != 0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_no_second got frames=%0d busy=%b required frames=0 busy=0",
                     rx_q.size(), tx_busy);
        end
        $display("ignored: byte %h cells %b", e, f.cells);
    endtask

    task automatic test_back_to_back();
        frame_t     f;
        bit         ok;
        bit         lok;
        int         len;
        int         k;
        logic [7:0] e;
        @(posedge clk); #1;
        tx_start = 1'b1;
        tx_data  = 8'h3C;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        @(posedge clk); #1;
        tx_data = 8'hC3;
        k = 0;
        while (tx_busy === 1'b1 && k < TIMEOUT) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (tx_busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_gap got tx=%b busy=%b required tx=1 busy=0", tx, tx_busy);
        end
        @(posedge clk); #1;
        tx_start = 1'b0;
        checks++;
        if (tx !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart got tx=%b busy=%b required tx=0 busy=1", tx, tx_busy);
        end
        for (int i = 0; i < 2; i++) begin
            get_frame(f, ok);
            get_len(len, lok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || f.cells !== build_cells(e) || !f.stable) begin
                errors++;
                $display("FAIL b2b_frame got %b required %b", f.cells, build_cells(e));
            end
            checks++;
            if (!lok || len != FRAME_BITS * CPB) begin
                errors++;
                $display("FAIL b2b_busy_len got %0d required %0d", len, FRAME_BITS * CPB);
            end
            $display("b2b: byte %h cells %b busy %0d", e, f.cells, len);
        end
    endtask

    task automatic test_reset_mid_frame();
        frame_t     f;
        bit         ok;
        bit         lok;
        int         len;
        logic [7:0] e;
        send_byte(8'h00);
        // Middle of data bit 4 (cell 5).
        repeat (5 * CPB + CPB / 2) @(posedge clk);
        #2;
        checks++;
        if (tx !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pre got tx=%b busy=%b required tx=0 busy=1", tx, tx_busy);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got tx=%b busy=%b required tx=1 busy=0", tx, tx_busy);
        end
        void'(exp_q.pop_back());
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        checks++;
        if (rx_q.size() != 0 || len_q.size() != 0) begin
            errors++;
            $display("FAIL abort_partial got frames=%0d required 0", rx_q.size());
        end
        send_byte(8'h81);
        get_frame(f, ok);
        get_len(len, lok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || f.cells !== build_cells(e) || !f.stable) begin
            errors++;
            $display("FAIL post_reset_frame got %b required %b", f.cells, build_cells(e));
        end
        checks++;
        if (!lok || len != FRAME_BITS * CPB) begin
            errors++;
            $display("FAIL post_reset_busy_len got %0d required %0d", len, FRAME_BITS * CPB);
        end
        $display("reset_mid: byte %h cells %b busy %0d", e, f.cells, len);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] bytes [2];
        logic       par [2];
        frame_t     f;
        bit         ok;
        logic [7:0] e;
        bytes = '{8'hAA, 8'h07};
        par   = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            send_byte(bytes[i]);
            get_frame(f, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || f.cells[9] !== par[i]) begin
                errors++;
                $display("FAIL parity_cell byte %h got %b required %b", e, f.cells[9], par[i]);
            end
            void'(len_q.size());
            $display("parity: byte %h cells %b", e, f.cells);
        end
        repeat (FRAME_BITS * CPB) @(posedge clk);
        len_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
